alu_muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide sequencer; owns the shared ALU port while busy.

---
 rtl/alu_muldiv_seq_pkg.sv | 18 +
 rtl/alu_muldiv_seq_if.sv | 25 ++
 rtl/alu_muldiv_seq_sign_fix.sv | 12 +
 rtl/alu_muldiv_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared constants for the iterative multiply/divide sequencer.
// Optional feature macro: MULDIV_EARLY_OUT_EN (early MUL termination).
package alu_muldiv_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] MDOP_MUL  = 3'd0;
  localparam logic [2:0] MDOP_DIV  = 3'd4;
  localparam logic [2:0] MDOP_DIVU = 3'd5;
  localparam logic [2:0] MDOP_REM  = 3'd6;
  localparam logic [2:0] MDOP_REMU = 3'd7;

  localparam logic [3:0] ALUOP_ADD  = 4'd0;
  localparam logic [3:0] ALUOP_SUB  = 4'd1;
  localparam logic [3:0] ALUOP_SLTU = 4'd3;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response handshake bundle between the execute stage and the sequencer.
interface alu_muldiv_seq_if;
  import alu_muldiv_seq_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, busy
  );

endinterface

// File: rtl/alu_muldiv_seq_sign_fix.sv
// Combinational conditional two's-complement negate (abs of signed operands, result fixup).
module alu_muldiv_seq_sign_fix #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] val_i,
  input  logic             neg_i,
  output logic [Width-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + Width'(1)) : val_i;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer driving a shared external ALU.
// MULDIV_EARLY_OUT_EN: stop MUL as soon as the remaining multiplier is zero.
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_muldiv_seq_if.slave md,
  output logic [XLEN-1:0] alu_src_a,
  output logic [XLEN-1:0] alu_src_b,
  output logic [3:0]      alu_op_code,
  input  logic [XLEN-1:0] alu_result
);

  typedef enum logic [2:0] {
    StIdle, StPrep, StMulStep, StDivCmp, StDivSub, StFixup, StDone
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(XLEN - 1);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]   acc_q, acc_d;      // MUL accumulator / DIV partial remainder
  logic [XLEN-1:0]   mcand_q, mcand_d;  // MUL multiplicand / DIV divisor
  logic [XLEN-1:0]   mplier_q, mplier_d; // MUL multiplier / DIV dividend
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d, ge_q, ge_d;

  logic            op_div, op_rem, op_signed;
  logic [XLEN-1:0] fix_a_val, fix_a_out, abs_b, rem_s;
  logic            fix_a_neg;

  assign op_div    = op_q inside {MDOP_DIV, MDOP_DIVU, MDOP_REM, MDOP_REMU};
  assign op_rem    = op_q inside {MDOP_REM, MDOP_REMU};
  assign op_signed = op_q inside {MDOP_DIV, MDOP_REM};
  assign rem_s     = {acc_q[XLEN-2:0], mplier_q[XLEN-1]};

  // One negator serves both |a| in PREP and the final result fixup.
  assign fix_a_val = (state_q == StFixup) ? ((op_div && !op_rem) ? quot_q : acc_q) : a_q;
  assign fix_a_neg = (state_q == StFixup) ? neg_q : (op_signed & a_q[XLEN-1]);

  alu_muldiv_seq_sign_fix #(.Width(XLEN)) u_fix_a (
    .val_i (fix_a_val),
    .neg_i (fix_a_neg),
    .val_o (fix_a_out)
  );

  alu_muldiv_seq_sign_fix #(.Width(XLEN)) u_fix_b (
    .val_i (b_q),
    .neg_i (op_signed & b_q[XLEN-1]),
    .val_o (abs_b)
  );

  assign md.req_ready  = (state_q == StIdle);
  assign md.busy       = (state_q != StIdle);
  assign md.rsp_valid  = (state_q == StDone);
  assign md.rsp_result = res_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    quot_d      = quot_q;
    res_d       = res_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    ge_d        = ge_q;
    alu_src_a   = '0;
    alu_src_b   = '0;
    alu_op_code = ALUOP_ADD;

    case (state_q)
      StIdle: begin
        if (md.req_valid) begin
          op_d    = md.req_op;
          a_d     = md.req_a;
          b_d     = md.req_b;
          state_d = StPrep;
        end
      end
      StPrep: begin
        acc_d  = '0;
        quot_d = '0;
        cnt_d  = '0;
        ge_d   = 1'b0;
        if (op_div) begin
          mplier_d = fix_a_out;
          mcand_d  = abs_b;
          neg_d    = op_signed & (op_rem ? a_q[XLEN-1] : (a_q[XLEN-1] ^ b_q[XLEN-1]));
          if (b_q == '0) begin
            res_d   = op_rem ? a_q : '1;
            state_d = StDone;
          end else begin
            state_d = StDivCmp;
          end
        end else begin
          mcand_d  = a_q;
          mplier_d = b_q;
          neg_d    = 1'b0;
          state_d  = StMulStep;
`ifdef MULDIV_EARLY_OUT_EN
          if (b_q == '0) state_d = StFixup;
`endif
        end
      end
      StMulStep: begin
        alu_src_a   = acc_q;
        alu_src_b   = mcand_q;
        alu_op_code = ALUOP_ADD;
        if (mplier_q[0]) acc_d = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef MULDIV_EARLY_OUT_EN
        if (cnt_q == CntLast || mplier_q[XLEN-1:1] == '0) state_d = StFixup;
`else
        if (cnt_q == CntLast) state_d = StFixup;
`endif
      end
      StDivCmp: begin
        alu_src_a   = rem_s;
        alu_src_b   = mcand_q;
        alu_op_code = ALUOP_SLTU;
        acc_d       = rem_s;
        mplier_d    = mplier_q << 1;
        // Bit shifted out of the remainder makes it a 33-bit value, always >= divisor.
        ge_d        = acc_q[XLEN-1] | ~alu_result[0];
        state_d     = StDivSub;
      end
      StDivSub: begin
        alu_src_a   = acc_q;
        alu_src_b   = mcand_q;
        alu_op_code = ALUOP_SUB;
        if (ge_q) acc_d = alu_result;
        quot_d  = {quot_q[XLEN-2:0], ge_q};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CntLast) ? StFixup : StDivCmp;
      end
      StFixup: begin
        res_d   = fix_a_out;
        state_d = StDone;
      end
      StDone: begin
        if (md.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= MDOP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quot_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      ge_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      quot_q   <= quot_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      ge_q     <= ge_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: vector table, random ops, handshake corners.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int MulLat = -1;
`else
  localparam int MulLat = 34;
`endif
  localparam int DivLat  = 66;
  localparam int ZeroLat = 1;
  localparam int MaxWait = 200;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] alu_src_a, alu_src_b, alu_result;
  logic [3:0]  alu_op_code;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vecs[16];

  alu_muldiv_seq_if md_if ();

  alu_muldiv_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .md          (md_if),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op_code (alu_op_code),
    .alu_result  (alu_result)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_result = '0;
    case (alu_op_code)
      ALUOP_ADD:  alu_result = alu_src_a + alu_src_b;
      ALUOP_SUB:  alu_result = alu_src_a - alu_src_b;
      ALUOP_SLTU: alu_result = {31'b0, alu_src_a < alu_src_b};
      default:    alu_result = '0;
    endcase
  end

  function automatic logic [31:0] ref_md(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MDOP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      MDOP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MDOP_REM:  return (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
      MDOP_REMU: return (b == 0) ? a : a % b;
      default:   return a * b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic start_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_if.req_op    = op;
    md_if.req_a     = a;
    md_if.req_b     = b;
    md_if.req_valid = 1'b1;
    chk("accept_ready", 32'(md_if.req_ready), 32'd1);
    @(posedge clk);
    #1;
    md_if.req_valid = 1'b0;
  endtask

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int lat);
    exp_t e;
    e.res = res;
    e.lat = lat;
    sb_q.push_back(e);
    start_req(op, a, b);
  endtask

  task automatic wait_rsp();
    exp_t e;
    int   cycles = 0;
    while (!md_if.rsp_valid && cycles < MaxWait) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    e = sb_q.pop_front();
    if (!md_if.rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout actual=no_rsp expected=%h", e.res);
      return;
    end
    chk("result", md_if.rsp_result, e.res);
    if (e.lat < 0) chk("latency_le", 32'(cycles <= MulLat + 35 && cycles <= 34), 32'd1);
    else           chk("latency", 32'(cycles), 32'(e.lat));
  endtask

  task automatic consume();
    md_if.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    md_if.rsp_ready = 1'b0;
    chk("idle_after_rsp", {30'b0, md_if.req_ready, md_if.rsp_valid}, 32'd2);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int lat);
    start_op(op, a, b, res, lat);
    wait_rsp();
    consume();
  endtask

  initial begin
    logic [2:0]  ops[5];
    logic [2:0]  op;
    logic [31:0] a, b;
    int          seen;

    ops = '{MDOP_MUL, MDOP_DIV, MDOP_DIVU, MDOP_REM, MDOP_REMU};
    vecs[0]  = '{MDOP_MUL,  32'd7,         32'd6,         32'd42,        MulLat};
    vecs[1]  = '{MDOP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DivLat};
    vecs[2]  = '{MDOP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DivLat};
    vecs[3]  = '{MDOP_DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, DivLat};
    vecs[4]  = '{MDOP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         DivLat};
    vecs[5]  = '{MDOP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, ZeroLat};
    vecs[6]  = '{MDOP_REM,  32'd5,         32'd0,         32'd5,         ZeroLat};
    vecs[7]  = '{MDOP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DivLat};
    vecs[8]  = '{MDOP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         DivLat};
    vecs[9]  = '{MDOP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         MulLat};
    vecs[10] = '{MDOP_MUL,  32'h1234_5678, 32'd0,         32'd0,         MulLat};
    vecs[11] = '{MDOP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, ZeroLat};
    vecs[12] = '{MDOP_REMU, 32'd7,         32'd0,         32'd7,         ZeroLat};
    vecs[13] = '{MDOP_DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, DivLat};
    vecs[14] = '{MDOP_REM,  32'd100,       32'hFFFF_FFF9, 32'd2,         DivLat};
    vecs[15] = '{MDOP_MUL,  32'h8000_0000, 32'd2,         32'd0,         MulLat};

    md_if.req_valid = 1'b0;
    md_if.req_op    = MDOP_MUL;
    md_if.req_a     = '0;
    md_if.req_b     = '0;
    md_if.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(md_if.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(md_if.rsp_valid), 32'd0);
    chk("rst_busy", 32'(md_if.busy), 32'd0);
    chk("rst_rsp_result", md_if.rsp_result, 32'd0);
    chk("rst_alu_src_a", alu_src_a, 32'd0);
    chk("rst_alu_src_b", alu_src_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op_code), 32'(ALUOP_ADD));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

    for (int i = 0; i < 8; i++) begin
      op = ops[$urandom_range(0, 4)];
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      run_op(op, a, b, ref_md(op, a, b),
             (op == MDOP_MUL) ? MulLat : ((b == 0) ? ZeroLat : DivLat));
    end

    // Hold the response off; a competing request must be ignored meanwhile.
    start_op(MDOP_DIVU, 32'd100, 32'd7, 32'd14, DivLat);
    wait_rsp();
    md_if.req_valid = 1'b1;
    md_if.req_op    = MDOP_MUL;
    md_if.req_a     = 32'd3;
    md_if.req_b     = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(md_if.rsp_valid), 32'd1);
      chk("hold_result", md_if.rsp_result, 32'd14);
      chk("hold_req_ready", 32'(md_if.req_ready), 32'd0);
    end
    md_if.req_valid = 1'b0;
    consume();
    chk("result_kept", md_if.rsp_result, 32'd14);

    // Reset in the middle of a division aborts without a response.
    start_req(MDOP_DIV, 32'd1000, 32'd3);
    repeat (20) @(posedge clk);
    #1;
    chk("mid_busy", 32'(md_if.busy), 32'd1);
    chk("mid_req_ready", 32'(md_if.req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_req_ready", 32'(md_if.req_ready), 32'd1);
    chk("abort_busy", 32'(md_if.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (md_if.rsp_valid) seen++;
    end
    chk("abort_no_rsp", 32'(seen), 32'd0);
    run_op(MDOP_DIVU, 32'd1000, 32'd3, 32'd333, DivLat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

●
